// File: rtl/i2c_master_write_n_if.sv
// Request/status bundle between a requester and the i2c_master_write_n engine.
// The requester owns divisor/start/i2c_data; the engine owns busy/done/ack_vec/ack.
interface i2c_master_write_n_if #(
    parameter int NBYTES = 2,
    parameter int DIV_W  = 8
);
    logic [DIV_W-1:0]    divisor;
    logic                start;
    logic [8*NBYTES-1:0] i2c_data;
    logic                busy;
    logic                done;
    logic [NBYTES-1:0]   ack_vec;
    logic                ack;

    // start is a request level: it is taken only on an edge where busy is low.
    // done pulses for exactly one clk cycle on the edge busy falls.
    modport master (
        output divisor, start, i2c_data,
        input  busy, done, ack_vec, ack
    );

    modport slave (
        input  divisor, start, i2c_data,
        output busy, done, ack_vec, ack
    );
endinterface

// File: rtl/i2c_master_write_n.sv
// Write-only I2C master: START, NBYTES bytes each followed by an ACK slot, STOP.
// Optional macro I2C_NACK_ABORT_EN: a NACK jumps straight to STOP.
module i2c_master_write_n #(
    parameter int NBYTES = 2,
    parameter int DIV_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    i2c_master_write_n_if.slave ctl,
    output logic                i2c_sclk,
    inout  wire                 i2c_sdat,
    output logic [2:0]          dbg_state
);

    localparam int MSB = 8 * NBYTES - 1;
    localparam int BW  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BIT   = 3'd2,
        S_ACK   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t              state;
    logic [DIV_W-1:0]    div_q;
    logic [DIV_W-1:0]    tick_cnt;
    logic                tick;
    logic [MSB:0]        shreg;
    logic [1:0]          phase;
    logic [2:0]          bit_idx;
    logic [BW-1:0]       byte_idx;
    logic                sda_oe;
    logic                busy_r;
    logic                done_r;
    logic [NBYTES-1:0]   ack_vec_r;
    logic                last_byte;
    logic                stop_now;

    assign tick      = (tick_cnt == div_q);
    assign last_byte = (byte_idx == BW'(NBYTES - 1));

`ifdef I2C_NACK_ABORT_EN
    assign stop_now  = last_byte || ack_vec_r[byte_idx];
`else
    assign stop_now  = last_byte;
`endif

    // Open drain: only ever pull low or let go.
    assign i2c_sdat    = sda_oe ? 1'b0 : 1'bz;
    assign ctl.busy    = busy_r;
    assign ctl.done    = done_r;
    assign ctl.ack_vec = ack_vec_r;
    assign ctl.ack     = ~|ack_vec_r;
    assign dbg_state   = state;

    // Free tick counter; restarted on accept so the first tick lands exactly one q later.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (state == S_IDLE && ctl.start) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            i2c_sclk  <= 1'b1;
            sda_oe    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            ack_vec_r <= '1;
            div_q     <= '0;
            shreg     <= '0;
            phase     <= 2'd0;
            bit_idx   <= 3'd0;
            byte_idx  <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ctl.start) begin
                        state     <= S_START;
                        shreg     <= ctl.i2c_data;
                        div_q     <= ctl.divisor;
                        ack_vec_r <= '1;
                        busy_r    <= 1'b1;
                        sda_oe    <= 1'b1;
                        i2c_sclk  <= 1'b1;
                        phase     <= 2'd0;
                        bit_idx   <= 3'd0;
                        byte_idx  <= '0;
                    end
                end

                // SDA already low with SCL high; hold for two ticks, then drop SCL.
                S_START: begin
                    if (tick) begin
                        if (phase == 2'd1) begin
                            state    <= S_BIT;
                            phase    <= 2'd0;
                            i2c_sclk <= 1'b0;
                            sda_oe   <= ~shreg[MSB];
                        end else begin
                            phase <= phase + 2'd1;
                        end
                    end
                end

                S_BIT: begin
                    if (tick) begin
                        phase <= phase + 2'd1;
                        case (phase)
                            2'd0: i2c_sclk <= 1'b1;
                            2'd1: i2c_sclk <= 1'b1;
                            2'd2: i2c_sclk <= 1'b0;
                            default: begin
                                shreg   <= shreg << 1;
                                bit_idx <= bit_idx + 3'd1;
                                if (bit_idx == 3'd7) begin
                                    state  <= S_ACK;
                                    sda_oe <= 1'b0;
                                end else begin
                                    sda_oe <= ~shreg[MSB-1];
                                end
                            end
                        endcase
                    end
                end

                // SDA released for the whole slot; the slave's answer is taken mid-high.
                S_ACK: begin
                    if (tick) begin
                        phase <= phase + 2'd1;
                        case (phase)
                            2'd0: i2c_sclk <= 1'b1;
                            2'd1: ack_vec_r[byte_idx] <= i2c_sdat;
                            2'd2: i2c_sclk <= 1'b0;
                            default: begin
                                if (stop_now) begin
                                    state  <= S_STOP;
                                    sda_oe <= 1'b1;
                                end else begin
                                    state    <= S_BIT;
                                    byte_idx <= byte_idx + BW'(1);
                                    sda_oe   <= ~shreg[MSB];
                                end
                            end
                        endcase
                    end
                end

                // SDA low/SCL low, then SCL high, then SDA released (the STOP edge).
                S_STOP: begin
                    if (tick) begin
                        phase <= phase + 2'd1;
                        case (phase)
                            2'd0: i2c_sclk <= 1'b1;
                            2'd1: sda_oe   <= 1'b0;
                            default: begin
                                state  <= S_IDLE;
                                phase  <= 2'd0;
                                busy_r <= 1'b0;
                                done_r <= 1'b1;
                            end
                        endcase
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    i2c_sclk <= 1'b1;
                    sda_oe   <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/i2c_master_write_n.md
I2C_MASTER_WRITE_N -- requirements
Module: i2c_master_write_n

Interface
REQ-001 SHALL have parameter NBYTES, default 2, range 1..4: number of data bytes per transaction, slave address byte included.
REQ-002 SHALL have parameter DIV_W, default 8: width of the divisor input.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port divisor, input, DIV_W bits: quarter-bit period is (divisor+1) clk cycles.
REQ-006 SHALL have port start, input, 1 bit: transaction request, sampled only when idle.
REQ-007 SHALL have port i2c_data, input, 8*NBYTES bits: payload; bit 8*NBYTES-1 is sent first.
REQ-008 SHALL have port i2c_sclk, output, 1 bit: I2C clock, driven high when idle.
REQ-009 SHALL have port i2c_sdat, inout, 1 bit: open-drain data; drives 0 or Z only.
REQ-010 SHALL have port busy, output, 1 bit: transaction in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse at end of transaction.
REQ-012 SHALL have port ack_vec, output, NBYTES bits: sampled ACK slot per byte, bit 0 = first byte sent; 0 means acked.
REQ-013 SHALL have port ack, output, 1 bit: high when all ack_vec bits are 0.

Function
REQ-014 SHALL generate a one-cycle tick every (divisor+1) clk cycles from a free counter; no derived clocks; q denotes one tick period.
REQ-015 SHALL latch i2c_data and divisor, clear ack_vec to all 1, and set busy on the edge where start=1 and busy=0; start while busy SHALL be ignored.
REQ-016 SHALL use FSM states IDLE -> START -> BIT -> ACK -> (BIT | STOP) -> IDLE.
REQ-017 START: SDA low with SCL high for 2q, then SCL low.
REQ-018 BIT and ACK slots: 4q each; SDA changes at phase 0 with SCL low; SCL high in phases 1-2; SCL low in phase 3.
REQ-019 ACK slot: SDA released; sample i2c_sdat into ack_vec[byte] at the end of phase 1.
REQ-020 SHALL send 8 bits MSB-first per byte, then one ACK slot; move to STOP after byte NBYTES-1.
REQ-021 STOP: SCL low/SDA low for 1q, then SCL high for 1q, then SDA released for 1q.
REQ-022 After STOP, SHALL return to IDLE, drop busy and pulse done for one cycle at the same edge.
REQ-023 Transaction length SHALL be (2 + 36*NBYTES + 3) * (divisor+1) clk cycles from the start-accept edge to the done edge.
REQ-024 ack_vec and ack SHALL hold their values until the next accepted start.
REQ-025 A divisor change mid-transaction SHALL have no effect until the next start.

Reset
REQ-026 On reset=1 at a clk edge, regardless of state: FSM=IDLE, i2c_sclk=1, i2c_sdat=Z, busy=0, done=0, ack_vec=all 1, ack=0, tick counter=0.
REQ-027 Reset mid-transfer SHALL release the bus on the next edge without generating STOP or done.

Configuration
REQ-028 Macro I2C_NACK_ABORT_EN defined: a 1 sampled in any ACK slot SHALL skip the remaining bytes and go directly to STOP; ack_vec bits of unsent bytes stay 1.
REQ-029 I2C_NACK_ABORT_EN undefined: all NBYTES bytes SHALL be sent regardless of ACK values.

Verification
REQ-030 NBYTES=2, divisor=0, data=0x4A3C, slave ACKs both bytes -> SDA bits 01001010,Z,00111100,Z; done 77 cycles after start; ack_vec=2'b00; ack=1.
REQ-031 Same as REQ-030 with divisor=3 -> done 308 cycles after start; SCL high time is 8 cycles per bit.
REQ-032 I2C_NACK_ABORT_EN defined, slave NACKs byte 0 -> STOP follows first ACK slot; done at 41 cycles; ack_vec=2'b11; ack=0.
REQ-033 I2C_NACK_ABORT_EN undefined, byte 0 NACKed, byte 1 ACKed -> done at 77 cycles; ack_vec=2'b01; ack=0.
REQ-034 start pulsed again at cycle 10 of a transfer -> ignored; single done at 77 cycles.
REQ-035 reset at cycle 20 of a transfer -> next edge: i2c_sclk=1, i2c_sdat=Z, busy=0; no done pulse.
